// File: rtl/dmem_pkg.sv
// Shared constants and state encoding for the data-memory responder.
// Defaults for DEPTH/LATENCY, wait-counter width, 2-bit FSM state codes.
package dmem_pkg;

  localparam int unsigned DMEM_DEPTH   = 1024;
  localparam int unsigned DMEM_LATENCY = 2;
  localparam int unsigned CNT_W        = 4;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'b00;
  localparam state_t S_WAIT = 2'b01;
  localparam state_t S_RESP = 2'b10;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: synchronous write, registered read.
// Ports: clk_i, rst_i (async low, read register only), we_i, re_i,
// clr_i (zero the read register), addr_i (word index), wdata_i, rdata_o.
module dmem_array #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic                     clr_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Storage contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end else if (clr_i) begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, valid/ready request and
// response channels, LATENCY wait states (1..15) before resp_valid_o.
// Ports: clk_i, rst_i (async, low); req_valid_i/req_ready_o/req_we_i/
// req_addr_i/req_wdata_i; resp_valid_o/resp_ready_i/resp_rdata_o/
// resp_err_o; busy_o (WAIT or RESP).
// Option: DMEM_ALIGN_CHECK_EN makes misaligned addresses an error.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = DMEM_DEPTH,
  parameter int unsigned LATENCY = DMEM_LATENCY
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        busy_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             err_q, err_d;

  logic             enter_resp;
  logic             op_we;
  logic [31:0]      op_addr;
  logic [31:0]      op_wdata;
  logic             op_bad;

  // With LATENCY==1 RESP is entered on the accept edge itself, before
  // the request has been latched, so the array sees the live inputs.
  assign op_we    = (state_q == S_IDLE) ? req_we_i    : we_q;
  assign op_addr  = (state_q == S_IDLE) ? req_addr_i  : addr_q;
  assign op_wdata = (state_q == S_IDLE) ? req_wdata_i : wdata_q;

`ifdef DMEM_ALIGN_CHECK_EN
  assign op_bad = (op_addr[31:2] >= DEPTH_W) ||
                  (op_addr[1:0] != 2'b00);
`else
  logic unused_lsb;
  assign unused_lsb = ^op_addr[1:0];
  assign op_bad = (op_addr[31:2] >= DEPTH_W);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          cnt_d   = LAT_M1;
          if (LATENCY == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (enter_resp) begin
      err_d = op_bad;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  logic arr_we;
  logic arr_re;
  logic arr_clr;

  // Single commit point: only the RESP-entry edge touches the array.
  assign arr_we  = enter_resp &  op_we & ~op_bad;
  assign arr_re  = enter_resp & ~op_we & ~op_bad;
  assign arr_clr = enter_resp & (op_we | op_bad);

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .clr_i   (arr_clr),
    .addr_i  (op_addr[2 +: AW]),
    .wdata_i (op_wdata),
    .rdata_o (resp_rdata_o)
  );

  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_err_o   = err_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule
